// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle of the UART framer: serial line in, byte and status strobes out.
// The slave modport belongs to the framer and the master modport to the line driver or consumer.
interface uart_rx_frame_if;
   logic       rx_sync;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       rx_busy;

   modport master (
      output rx_sync,
      input  rx_data,
      input  rx_valid,
      input  frame_error,
      input  rx_busy
   );

   modport slave (
      input  rx_sync,
      output rx_data,
      output rx_valid,
      output frame_error,
      output rx_busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 receive framer: detects the start edge, samples each bit once at mid-bit,
// and publishes good bytes with a one-cycle strobe. Framing errors raise a separate strobe.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic          clk,
   input  logic          reset,
   uart_rx_frame_if.slave rx
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
         $error("uart_rx_frame: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   logic [2:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;
   logic             half_done_s;
   logic             bit_done_s;

   // Terminal counts for the half-bit start sample and the full-bit data/stop samples.
   always_comb begin
      half_done_s = 1'b0;
      bit_done_s  = 1'b0;
      if (cnt_r == HALF_LAST) begin
         half_done_s = 1'b1;
      end else begin
         half_done_s = 1'b0;
      end
      if (cnt_r == BIT_LAST) begin
         bit_done_s = 1'b1;
      end else begin
         bit_done_s = 1'b0;
      end
   end

   // Frame FSM; strobes default low so each one lasts exactly a single cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         cnt_r          <= CNT_ZERO;
         bit_idx_r      <= 3'd0;
         shift_r        <= 8'h00;
         rx.rx_data     <= 8'h00;
         rx.rx_valid    <= 1'b0;
         rx.frame_error <= 1'b0;
         rx.rx_busy     <= 1'b0;
      end else begin
         rx.rx_valid    <= 1'b0;
         rx.frame_error <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!rx.rx_sync) begin
                  state_r    <= ST_START;
                  cnt_r      <= CNT_ZERO;
                  rx.rx_busy <= 1'b1;
               end
            end
            ST_START: begin
               if (half_done_s) begin
                  cnt_r <= CNT_ZERO;
                  if (!rx.rx_sync) begin
                     state_r   <= ST_DATA;
                     bit_idx_r <= 3'd0;
                  end else begin
                     // Line went back high before mid start bit: treat as a glitch.
                     state_r    <= ST_IDLE;
                     rx.rx_busy <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (bit_done_s) begin
                  cnt_r              <= CNT_ZERO;
                  shift_r[bit_idx_r] <= rx.rx_sync;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= ST_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (bit_done_s) begin
                  cnt_r <= CNT_ZERO;
                  if (rx.rx_sync) begin
                     // Returning to IDLE mid stop bit lets a back-to-back start be seen on its first low cycle.
                     state_r     <= ST_IDLE;
                     rx.rx_data  <= shift_r;
                     rx.rx_valid <= 1'b1;
                     rx.rx_busy  <= 1'b0;
                  end else begin
                     state_r        <= ST_WAIT_IDLE;
                     rx.frame_error <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_WAIT_IDLE: begin
               if (rx.rx_sync) begin
                  state_r    <= ST_IDLE;
                  cnt_r      <= CNT_ZERO;
                  rx.rx_busy <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= CNT_ZERO;
               rx.rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
